block_aligner: RTL and testbench

BLOCK_ALIGNER -- requirements
Module: block_aligner

---
 rtl/block_aligner.sv | 180 ++++++++++++++++++
 tb/tb_block_aligner.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/block_aligner.sv
// Block aligner: finds the 2-bit sync header in a gearbox window, verifies it, then tracks lock.
// Latency: buffer_dv to outputs is 2 cycles. There is no backpressure; each captured buffer is evaluated once.
module block_aligner #(
    parameter int BLOCK_W  = 66,
    parameter int BUF_W    = 194,
    parameter int N_SEEK   = 2,
    parameter int LOCK_CNT = 32,
    parameter int ERR_WIN  = 64,
    parameter int ERR_MAX  = 16
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [BUF_W-1:0]                   gbox_buffer,
    input  logic [$clog2(BUF_W-BLOCK_W)-1:0]   gbox_cnt,
    input  logic                               buffer_dv,
    input  logic                               realign_i,
    output logic [$clog2(BLOCK_W)-1:0]         block_offset,
    output logic                               locked_o,
    output logic                               hdr_err_o,
    output logic [1:0]                         state_o
);

    localparam int R     = BLOCK_W / N_SEEK;
    localparam int OFF_W = $clog2(BLOCK_W);
    localparam int SW    = $clog2(BLOCK_W + 1);
    localparam int BW    = $clog2(BUF_W);
    localparam int MAXC  = (LOCK_CNT > ERR_WIN) ? LOCK_CNT : ERR_WIN;
    localparam int CW    = $clog2(MAXC + 1);
    localparam int SRC_W = (N_SEEK > 1) ? $clog2(N_SEEK) : 1;

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    if ((BLOCK_W % N_SEEK) != 0) begin : g_bad_seek
        $error("BLOCK_W must be a multiple of N_SEEK");
    end

    function automatic logic hdr_ok(input logic [BLOCK_W:0] s, input logic [OFF_W-1:0] k);
        logic [SW-1:0] idx;
        logic [1:0]    h;
        idx = SW'(BLOCK_W) - SW'(k);
        h   = {s[idx], s[idx - 1'b1]};
        return (h == 2'b01) || (h == 2'b10);
    endfunction

    // Step within the seeker's own sub-range, wrapping to its base.
    function automatic logic [OFF_W-1:0] adv(input int i, input logic [OFF_W-1:0] p);
        if (p == OFF_W'((i + 1) * R - 1)) return OFF_W'(i * R);
        return p + 1'b1;
    endfunction

    logic [BLOCK_W:0]   r_slice;
    logic               r_eval;
    logic [1:0]         r_state;
    logic [OFF_W-1:0]   r_offset;
    logic               r_locked;
    logic               r_hdr_err;
    logic [OFF_W-1:0]   r_seek [N_SEEK];
    logic [SRC_W-1:0]   r_src;
    logic [CW-1:0]      r_vcnt;
    logic [CW-1:0]      r_hcnt;
    logic [CW-1:0]      r_ecnt;

    logic [BW-1:0]      w_base;
    logic [N_SEEK-1:0]  w_seek_ok;
    logic               w_any;
    logic [SRC_W-1:0]   w_win;
    logic               w_off_ok;

    assign w_base   = BW'(BUF_W - 1) - BW'(gbox_cnt);
    assign w_off_ok = hdr_ok(r_slice, r_offset);

    always_comb begin
        w_seek_ok = '0;
        w_any     = 1'b0;
        w_win     = '0;
        for (int i = 0; i < N_SEEK; i++) begin
            w_seek_ok[i] = hdr_ok(r_slice, r_seek[i]);
        end
        for (int i = N_SEEK - 1; i >= 0; i--) begin
            if (w_seek_ok[i]) begin
                w_any = 1'b1;
                w_win = SRC_W'(i);
            end
        end
    end

    // The captured slice carries data only; it is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (buffer_dv) begin
            r_slice <= gbox_buffer[w_base -: BLOCK_W + 1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_eval    <= 1'b0;
            r_state   <= ST_SEARCH;
            r_offset  <= '0;
            r_locked  <= 1'b0;
            r_hdr_err <= 1'b0;
            r_src     <= '0;
            r_vcnt    <= '0;
            r_hcnt    <= '0;
            r_ecnt    <= '0;
            for (int i = 0; i < N_SEEK; i++) begin
                r_seek[i] <= OFF_W'(i * R);
            end
        end else begin
            r_eval    <= buffer_dv;
            r_hdr_err <= 1'b0;
            if (realign_i) begin
                r_state  <= ST_SEARCH;
                r_locked <= 1'b0;
                r_vcnt   <= '0;
                r_hcnt   <= '0;
                r_ecnt   <= '0;
                for (int i = 0; i < N_SEEK; i++) begin
                    r_seek[i] <= OFF_W'(i * R);
                end
            end else if (r_eval) begin
                case (r_state)
                    ST_SEARCH: begin
                        for (int i = 0; i < N_SEEK; i++) begin
                            if (!w_seek_ok[i]) r_seek[i] <= adv(i, r_seek[i]);
                        end
                        if (w_any) begin
                            r_offset <= r_seek[w_win];
                            r_src    <= w_win;
                            r_vcnt   <= CW'(1);
                            r_state  <= ST_VERIFY;
                        end
                    end
                    ST_VERIFY: begin
                        if (w_off_ok) begin
                            if (r_vcnt >= CW'(LOCK_CNT - 1)) begin
                                r_state  <= ST_LOCKED;
                                r_locked <= 1'b1;
                                r_vcnt   <= '0;
                                r_hcnt   <= '0;
                                r_ecnt   <= '0;
                            end else begin
                                r_vcnt <= r_vcnt + 1'b1;
                            end
                        end else begin
                            r_state <= ST_SEARCH;
                            r_vcnt  <= '0;
                            for (int i = 0; i < N_SEEK; i++) begin
                                if (SRC_W'(i) == r_src) r_seek[i] <= adv(i, r_seek[i]);
                            end
                        end
                    end
                    ST_LOCKED: begin
                        r_hdr_err <= !w_off_ok;
                        if (!w_off_ok && (r_ecnt == CW'(ERR_MAX - 1))) begin
                            r_state  <= ST_SEARCH;
                            r_locked <= 1'b0;
                            r_hcnt   <= '0;
                            r_ecnt   <= '0;
                        end else if (r_hcnt == CW'(ERR_WIN - 1)) begin
                            r_hcnt <= '0;
                            r_ecnt <= '0;
                        end else begin
                            r_hcnt <= r_hcnt + 1'b1;
                            if (!w_off_ok) r_ecnt <= r_ecnt + 1'b1;
                        end
                    end
                    default: r_state <= ST_SEARCH;
                endcase
            end
        end
    end

    assign block_offset = r_offset;
    assign locked_o     = r_locked;
    assign hdr_err_o    = r_hdr_err;
    assign state_o      = r_state;

endmodule

// File: tb/tb_block_aligner.sv
// Scoreboard bench for block_aligner: directed evaluates push expectations, a monitor checks each result.
module tb_block_aligner;

    localparam int BLOCK_W = 66;
    localparam int BUF_W   = 194;
    localparam logic [1:0] S_SEARCH = 2'd0;
    localparam logic [1:0] S_VERIFY = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic [BUF_W-1:0] gbox_buffer;
    logic [6:0]       gbox_cnt;
    logic             buffer_dv;
    logic             realign_i;
    logic [6:0]       block_offset;
    logic             locked_o;
    logic             hdr_err_o;
    logic [1:0]       state_o;

    always #5 clk_i = ~clk_i;

    block_aligner dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .gbox_buffer  (gbox_buffer),
        .gbox_cnt     (gbox_cnt),
        .buffer_dv    (buffer_dv),
        .realign_i    (realign_i),
        .block_offset (block_offset),
        .locked_o     (locked_o),
        .hdr_err_o    (hdr_err_o),
        .state_o      (state_o)
    );

    typedef struct {
        logic [1:0] st;
        logic [6:0] off;
        logic       lk;
        logic       er;
        logic       co;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk      = 0;
    int   n_pass     = 0;
    int   err_pulses = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    // Slice whose only valid header sits at offset k: ones down to bit 66-k, zeros below.
    function automatic logic [66:0] one_hdr(input int k);
        logic [66:0] s;
        s = '0;
        for (int j = 0; j <= k; j++) s[66-j] = 1'b1;
        return s;
    endfunction

    task automatic send(input logic [66:0] s, input int cnt, input logic [1:0] st,
                        input logic [6:0] off, input logic lk, input logic er,
                        input logic co, input logic rl);
        logic [BUF_W-1:0] b;
        for (int j = 0; j < BUF_W; j++) b[j] = 1'($urandom_range(0, 1));
        for (int j = 0; j <= 66; j++) b[127-cnt+j] = s[j];
        @(negedge clk_i);
        gbox_buffer = b;
        gbox_cnt    = 7'(cnt);
        buffer_dv   = 1'b1;
        exp_q.push_back('{st, off, lk, er, co});
        @(negedge clk_i);
        buffer_dv = 1'b0;
        realign_i = rl;
        @(negedge clk_i);
        realign_i = 1'b0;
        repeat (5) @(negedge clk_i);
    endtask

    // Monitor: an evaluate follows each captured buffer; results are visible after the next edge.
    initial begin
        logic dv_prev;
        logic seen;
        int   ev;
        exp_t e;
        dv_prev = 1'b0;
        ev      = 0;
        forever begin
            @(posedge clk_i);
            seen    = dv_prev && rst_ni;
            dv_prev = buffer_dv;
            if (seen) begin
                @(negedge clk_i);
                ev++;
                if (exp_q.size() == 0) begin
                    chk($sformatf("unexpected_eval@%0d", ev), 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("state@%0d", ev), 32'(state_o), 32'(e.st));
                    chk($sformatf("locked@%0d", ev), 32'(locked_o), 32'(e.lk));
                    chk($sformatf("hdr_err@%0d", ev), 32'(hdr_err_o), 32'(e.er));
                    if (e.co) chk($sformatf("offset@%0d", ev), 32'(block_offset), 32'(e.off));
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_i);
            if (hdr_err_o) err_pulses++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1);
    end

    initial begin
        logic [66:0] d5;
        logic [66:0] d6;
        logic [66:0] d40;
        logic [66:0] dz;
        logic        bad;
        d5  = one_hdr(5);
        d6  = one_hdr(6);
        d40 = one_hdr(40);
        dz  = '0;

        rst_ni      = 1'b0;
        gbox_buffer = '0;
        gbox_cnt    = '0;
        buffer_dv   = 1'b0;
        realign_i   = 1'b0;
        #12;
        chk("rst_state", 32'(state_o), 32'(S_SEARCH));
        chk("rst_offset", 32'(block_offset), 32'd0);
        chk("rst_locked", 32'(locked_o), 32'd0);
        chk("rst_hdr_err", 32'(hdr_err_o), 32'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        // Header at 5: seeker0 sweeps 0..4, wins on evaluate 6, locks on evaluate 37.
        for (int i = 1; i <= 5; i++) send(d5, 0, S_SEARCH, 7'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 6; i <= 36; i++) send(d5, 0, S_VERIFY, 7'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        send(d5, 0, S_LOCKED, 7'd5, 1'b1, 1'b0, 1'b1, 1'b0);

        // Window 1: first 15 bad; window 2: last 15 bad -> lock held, counts cleared at window end.
        for (int i = 0; i < 64; i++) begin
            bad = (i < 15);
            send(bad ? dz : d5, (i * 7) % 128, S_LOCKED, 7'd5, 1'b1, bad, 1'b1, 1'b0);
        end
        for (int i = 0; i < 64; i++) begin
            bad = (i >= 49);
            send(bad ? dz : d5, (i * 11) % 128, S_LOCKED, 7'd5, 1'b1, bad, 1'b1, 1'b0);
        end
        // Window 3: 16 bad in a row -> lock lost on the 16th, offset held.
        for (int i = 0; i < 15; i++) send(dz, 3, S_LOCKED, 7'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        send(dz, 3, S_SEARCH, 7'd5, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("err_pulse_count", 32'(err_pulses), 32'd46);

        // Seeker0 still holds 5: immediate VERIFY, then a bad header at count 20.
        for (int i = 0; i < 20; i++) send(d5, 9, S_VERIFY, 7'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        send(dz, 9, S_SEARCH, 7'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        // Supplying seeker moved to 6: header at 6 is found on the first search evaluate.
        send(d6, 20, S_VERIFY, 7'd6, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 30; i++) send(d6, 20, S_VERIFY, 7'd6, 1'b0, 1'b0, 1'b1, 1'b0);
        send(d6, 20, S_LOCKED, 7'd6, 1'b1, 1'b0, 1'b1, 1'b0);

        // Realign coincident with an evaluate while locked; seekers restart at 0/33.
        send(d6, 127, S_SEARCH, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 6; i++) send(d6, 127, S_SEARCH, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(d6, 127, S_VERIFY, 7'd6, 1'b0, 1'b0, 1'b1, 1'b0);

        // Standalone realign, then header at 40: seeker1 (from 33) wins on evaluate 8.
        @(negedge clk_i);
        realign_i = 1'b1;
        @(negedge clk_i);
        realign_i = 1'b0;
        repeat (3) @(negedge clk_i);
        for (int i = 1; i <= 7; i++) send(d40, 37, S_SEARCH, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(d40, 37, S_VERIFY, 7'd40, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 30; i++) send(d40, 37, S_VERIFY, 7'd40, 1'b0, 1'b0, 1'b1, 1'b0);
        send(d40, 37, S_LOCKED, 7'd40, 1'b1, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-lock: outputs clear before the next clock edge.
        repeat (4) @(negedge clk_i);
        chk("pre_rst_locked", 32'(locked_o), 32'd1);
        @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_locked", 32'(locked_o), 32'd0);
        chk("arst_state", 32'(state_o), 32'(S_SEARCH));
        chk("arst_offset", 32'(block_offset), 32'd0);
        chk("arst_hdr_err", 32'(hdr_err_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        repeat (10) @(negedge clk_i);
        chk("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
